// File: rtl/decoder_pkg.sv
// Shared decode constants, output-stage states and the decode function.
// Used by the core and the pipelined top.
package decoder_pkg;

    localparam logic MODE_ONEHOT = 1'b0;
    localparam logic MODE_THERM  = 1'b1;

    localparam int SEL_MAX = 6;
    localparam int OUT_MAX = 2 ** SEL_MAX;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ostate_e;

    typedef struct packed {
        logic [OUT_MAX-1:0] word;
        logic               range_err;
    } dec_t;

    // Decode at the widest legal size; callers keep the low out_n bits.
    function automatic dec_t decode_word(
        input logic [SEL_MAX-1:0] sel,
        input logic               en,
        input logic               mode,
        input int unsigned        out_n
    );
        dec_t r;
        r.word      = '0;
        r.range_err = 1'b0;
        if (en) begin
            if (32'(sel) >= out_n) begin
                r.range_err = 1'b1;
            end else begin
                for (int i = 0; i < OUT_MAX; i++) begin
                    if (mode == MODE_THERM)
                        r.word[i] = (i <= int'(sel));
                    else
                        r.word[i] = (i == int'(sel));
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/decoder_core.sv
// Combinational N-to-2^N decoder, one-hot or thermometer.
// Flags codes at or above OUT_N as a range error with an all-zero word.
module decoder_core
    import decoder_pkg::*;
#(
    parameter int SEL_W = 2,
    parameter int OUT_N = 2 ** SEL_W
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    input  logic             mode,
    output logic [OUT_N-1:0] word,
    output logic             range_err
);

    generate
        if (SEL_W < 1 || SEL_W > SEL_MAX) begin : g_bad_sel_w
            $error("decoder_core: SEL_W out of range 1..6");
        end
        if (OUT_N > 2 ** SEL_W || OUT_N < 2) begin : g_bad_out_n
            $error("decoder_core: OUT_N out of range 2..2**SEL_W");
        end
    endgenerate

    logic [SEL_MAX-1:0] sel_x;
    dec_t               d;
    logic               spill;

    // Zero-extend the code to the package's widest select.
    always_comb begin
        sel_x            = '0;
        sel_x[SEL_W-1:0] = sel;
    end

    assign d = decode_word(sel_x, en, mode, OUT_N);

    // Bits above OUT_N are zero by construction; fold them in so any
    // stray high bit shows up as a range error instead of vanishing.
    generate
        if (OUT_N < OUT_MAX) begin : g_spill
            assign spill = |d.word[OUT_MAX-1:OUT_N];
        end else begin : g_no_spill
            assign spill = 1'b0;
        end
    endgenerate

    assign word      = d.word[OUT_N-1:0];
    assign range_err = d.range_err | spill;

endmodule

// File: rtl/decoder_nx2n_pipe.sv
// Decoder with a one-deep valid/ready output register and a
// saturating counter of accepted out-of-range requests.
module decoder_nx2n_pipe
    import decoder_pkg::*;
#(
    parameter int SEL_W = 2,
    parameter int OUT_N = 2 ** SEL_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_N-1:0] y,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    generate
        if (OUT_N > 2 ** SEL_W || OUT_N < 2) begin : g_bad_out_n
            $error("decoder_nx2n_pipe: OUT_N out of range 2..2**SEL_W");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("decoder_nx2n_pipe: CNT_W must be at least 1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    ostate_e          state_q, state_d;
    logic [OUT_N-1:0] y_q, y_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [OUT_N-1:0] dec_word;
    logic             dec_err;
    logic             accept;

    decoder_core #(
        .SEL_W (SEL_W),
        .OUT_N (OUT_N)
    ) u_core (
        .sel       (sel),
        .en        (en),
        .mode      (mode),
        .word      (dec_word),
        .range_err (dec_err)
    );

    // Ready only looks at the register state, never at clr.
    assign in_ready = (state_q == ST_EMPTY) || out_ready;
    assign accept   = in_valid && in_ready;

    // Output register, state and counter; reset drops any held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            y_q     <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: clr beats accept; drain clears valid but keeps data.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = ST_EMPTY;
            y_d     = '0;
            err_d   = 1'b0;
            cnt_d   = '0;
        end else if (accept) begin
            state_d = ST_FULL;
            y_d     = dec_word;
            err_d   = dec_err;
            if (dec_err && cnt_q != CNT_MAX)
                cnt_d = cnt_q + CNT_ONE;
        end else if (state_q == ST_FULL && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign y         = y_q;
    assign err       = err_q;
    assign err_cnt   = cnt_q;

endmodule

// File: doc/decoder_nx2n_pipe.md
DECODER_NX2N_PIPE -- requirements
Module: decoder_nx2n_pipe

Interface
REQ-001 SHALL have parameter SEL_W, default 2, select width in bits (legal range 1..6).
REQ-002 SHALL have parameter OUT_N, default 2**SEL_W, number of decoded outputs (legal range 2..2**SEL_W).
REQ-003 SHALL have parameter CNT_W, default 8, error-counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 clr  input  1  synchronous clear of the output stage and the error counter.
REQ-007 in_valid  input  1  upstream request valid.
REQ-008 in_ready  output  1  block can accept a request this cycle.
REQ-009 sel  input  SEL_W  code to decode.
REQ-010 en  input  1  decode enable, sampled with the request.
REQ-011 mode  input  1  0 = one-hot, 1 = thermometer, sampled with the request.
REQ-012 out_valid  output  1  registered result valid.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 y  output  OUT_N  registered decoded word, active-high.
REQ-015 err  output  1  registered flag: the held result came from out-of-range sel.
REQ-016 err_cnt  output  CNT_W  saturating count of accepted out-of-range requests.

Function
REQ-017 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-018 A request SHALL be accepted when in_valid && in_ready at a rising edge; result visible on y/err/out_valid the following cycle (latency 1).
REQ-019 Output stage states: EMPTY (out_valid=0) and FULL (out_valid=1); EMPTY->FULL on accept; FULL->EMPTY on out_ready && !accept; FULL->FULL with new data on out_ready && accept.
REQ-020 While FULL && !out_ready, y, err and out_valid SHALL hold stable.
REQ-021 en=0 at accept: y=0, err=0, out_valid still set (valid empty result).
REQ-022 mode=0, sel<OUT_N: y[sel]=1, all other bits 0, err=0.
REQ-023 mode=1, sel<OUT_N: y[i]=1 for all i<=sel, else 0, err=0.
REQ-024 en=1, sel>=OUT_N (either mode): y=0, err=1.
REQ-025 err_cnt SHALL increment by 1 on each accept with err condition; at 2**CNT_W-1 it SHALL hold (saturate, no wrap).
REQ-026 clr=1: next cycle out_valid=0, y=0, err=0, err_cnt=0; any request accepted in the same cycle is discarded and not counted (clr wins).
REQ-027 in_ready SHALL remain (!out_valid || out_ready) during clr; no combinational path from clr to in_ready.

Reset
REQ-028 rst_n=0 SHALL asynchronously force out_valid=0, y=0, err=0, err_cnt=0.
REQ-029 Reset asserted mid-transaction SHALL drop the held result without handshake; first accept after deassertion behaves as from EMPTY.
REQ-030 in_ready SHALL be 1 while in reset and immediately after deassertion.

Structure
REQ-031 Shared package decoder_pkg SHALL hold the mode constants (MODE_ONEHOT=0, MODE_THERM=1) and a function computing the decoded word and range error.
REQ-032 The combinational decode SHALL be a sub-module decoder_core (sel, en, mode -> word, range_err); decoder_nx2n_pipe adds the handshake register and counter.
REQ-033 Elaboration SHALL fail if OUT_N > 2**SEL_W or OUT_N < 2.

Verification
REQ-034 Default params, out_ready=1, mode=0, en=1, sel 0..3 back-to-back -> y=0001,0010,0100,1000 one cycle after each accept, err=0.
REQ-035 mode=1, sel=2 -> y=0111; sel=0 -> y=0001; en=0, sel=3 -> y=0000, out_valid=1.
REQ-036 out_ready=0 for 3 cycles after accept of sel=1 -> in_ready=0, y=0010 held; out_ready=1 with in_valid=1, sel=3 -> y=1000 next cycle, out_valid never drops.
REQ-037 OUT_N=3: sel=3 accepted 300 times with CNT_W=8 -> y=000, err=1 each result, err_cnt stops at 255.
REQ-038 clr together with accept of out-of-range sel -> out_valid=0, err_cnt=0 next cycle.
REQ-039 rst_n pulled low asynchronously while FULL -> out_valid, y, err, err_cnt read 0 before next clk edge; in_ready=1.
